// File: rtl/oreg_pkg.sv
// Shared types and constants for the output-register snapshot bank.
package oreg_pkg;
  localparam int OREG_DATA_W = 32;

  typedef enum logic {RUN = 1'b0, FROZEN = 1'b1} state_t;

  typedef logic signed [OREG_DATA_W-1:0] chan_word_t;

  localparam logic MODE_LAST = 1'b0;
  localparam logic MODE_SUM  = 1'b1;
endpackage

// File: rtl/oreg_window_accum.sv
// One channel of window reduction.
// The output is combinational for the sample that completes the window.
module oreg_window_accum
  import oreg_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_first,
  input  logic              i_mode,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_result
);
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_base;
  logic [DATA_W-1:0] w_sum;

  // The first sample of a window restarts the sum without needing a clear cycle.
  assign w_base   = i_first ? '0 : r_acc;
  assign w_sum    = w_base + i_data;
  assign o_result = (i_mode == MODE_SUM) ? w_sum : i_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_valid) begin
      r_acc <= w_sum;
    end
  end
endmodule

// File: rtl/oreg_snapshot_bank.sv
// NUM_CH channel output bank with decimation windows, sequence count,
// and freeze handshake with a one-entry shadow and saturating drop counter.
module oreg_snapshot_bank
  import oreg_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 32,
  parameter int DECIM_W = 16,
  parameter int DROP_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] sample_data_i,
  input  logic [DECIM_W-1:0]       decim_i,
  input  logic                     mode_i,
  input  logic                     freeze_i,
  output logic [NUM_CH*DATA_W-1:0] oreg_o,
  output logic [CNT_W-1:0]         oreg_count_o,
  output logic                     frozen_o,
  output logic [DROP_W-1:0]        drop_count_o
);
  logic [DECIM_W-1:0]       r_win_cnt;
  logic [DECIM_W-1:0]       r_decim;
  logic                     r_mode;
  logic [DECIM_W-1:0]       w_decim_eff;
  logic                     w_mode_eff;
  logic                     w_first;
  logic                     w_complete;
  logic [NUM_CH*DATA_W-1:0] w_result;

  logic [CNT_W-1:0]         r_seq;
  logic [CNT_W-1:0]         w_seq_next;

  state_t                   r_state;
  logic [NUM_CH*DATA_W-1:0] r_oreg;
  logic [CNT_W-1:0]         r_count;
  logic [NUM_CH*DATA_W-1:0] r_shadow;
  logic [CNT_W-1:0]         r_shadow_cnt;
  logic                     r_shadow_vld;
  logic [DROP_W-1:0]        r_drop;

  // Controls are taken live on the first sample so a window of one works.
  assign w_first     = sample_valid_i && (r_win_cnt == '0);
  assign w_decim_eff = w_first ? decim_i : r_decim;
  assign w_mode_eff  = w_first ? mode_i : r_mode;
  assign w_complete  = sample_valid_i && (r_win_cnt == w_decim_eff);
  assign w_seq_next  = r_seq + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_cnt <= '0;
      r_decim   <= '0;
      r_mode    <= MODE_LAST;
    end else if (sample_valid_i) begin
      if (w_first) begin
        r_decim <= decim_i;
        r_mode  <= mode_i;
      end
      r_win_cnt <= w_complete ? '0 : r_win_cnt + DECIM_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq <= '0;
    end else if (w_complete) begin
      r_seq <= w_seq_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      oreg_window_accum #(
        .DATA_W (DATA_W)
      ) u_accum (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (sample_valid_i),
        .i_first  (w_first),
        .i_mode   (w_mode_eff),
        .i_data   (sample_data_i[gi*DATA_W +: DATA_W]),
        .o_result (w_result[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_oreg       <= '0;
      r_count      <= '0;
      r_shadow     <= '0;
      r_shadow_cnt <= '0;
      r_shadow_vld <= 1'b0;
      r_drop       <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (freeze_i) begin
            r_state <= FROZEN;
            if (w_complete) begin
              r_shadow     <= w_result;
              r_shadow_cnt <= w_seq_next;
              r_shadow_vld <= 1'b1;
            end
          end else if (w_complete) begin
            r_oreg  <= w_result;
            r_count <= w_seq_next;
          end
        end
        FROZEN: begin
          if (!freeze_i) begin
            r_state      <= RUN;
            r_shadow_vld <= 1'b0;
            // A fresh window on the release edge supersedes the shadow.
            if (w_complete) begin
              r_oreg  <= w_result;
              r_count <= w_seq_next;
            end else if (r_shadow_vld) begin
              r_oreg  <= r_shadow;
              r_count <= r_shadow_cnt;
            end
          end else if (w_complete) begin
            r_shadow     <= w_result;
            r_shadow_cnt <= w_seq_next;
            r_shadow_vld <= 1'b1;
            if (r_shadow_vld && (r_drop != '1)) begin
              r_drop <= r_drop + DROP_W'(1);
            end
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign oreg_o       = r_oreg;
  assign oreg_count_o = r_count;
  assign frozen_o     = (r_state == FROZEN);
  assign drop_count_o = r_drop;
endmodule

// File: tb/tb_oreg_snapshot_bank.sv
// Scoreboard bench for oreg_snapshot_bank: expected publishes are queued with
// the stimulus and checked when the outputs change.
module tb_oreg_snapshot_bank;
  import oreg_pkg::*;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int CW  = 32;
  localparam int DCW = 16;
  localparam int DRW = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_valid_i;
  logic [NCH*DW-1:0]  sample_data_i;
  logic [DCW-1:0]     decim_i;
  logic               mode_i;
  logic               freeze_i;
  logic [NCH*DW-1:0]  oreg_o;
  logic [CW-1:0]      oreg_count_o;
  logic               frozen_o;
  logic [DRW-1:0]     drop_count_o;

  typedef struct {
    logic [NCH*DW-1:0] d;
    logic [CW-1:0]     c;
  } exp_t;

  exp_t              q[$];
  int                tb_total = 0;
  int                tb_bad   = 0;
  int                tb_seq   = 0;
  int                tb_hold  = 0;
  bit                tb_in_rst = 1'b1;
  logic [NCH*DW-1:0] prev_d = '0;
  logic [CW-1:0]     prev_c = '0;

  oreg_snapshot_bank #(
    .NUM_CH (NCH), .DATA_W (DW), .CNT_W (CW), .DECIM_W (DCW), .DROP_W (DRW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sample_valid_i (sample_valid_i),
    .sample_data_i  (sample_data_i),
    .decim_i        (decim_i),
    .mode_i         (mode_i),
    .freeze_i       (freeze_i),
    .oreg_o         (oreg_o),
    .oreg_count_o   (oreg_count_o),
    .frozen_o       (frozen_o),
    .drop_count_o   (drop_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    tb_total++;
    if (got !== want) begin
      tb_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [NCH*DW-1:0] pk(input chan_word_t a, input chan_word_t b,
                                           input chan_word_t c, input chan_word_t d);
    return {d, c, b, a};
  endfunction

  // Every change of the published pair must match the oldest queued window.
  always @(negedge clk) begin
    if (!tb_in_rst && (oreg_o !== prev_d || oreg_count_o !== prev_c)) begin
      if (q.size() == 0) begin
        chk("unexp_pub_data", oreg_o, prev_d);
        chk("unexp_pub_cnt", oreg_count_o, prev_c);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pub_data", oreg_o, e.d);
        chk("pub_cnt", oreg_count_o, e.c);
        $display("publish count=%0d data=%h", oreg_count_o, oreg_o);
      end
    end
    prev_d = oreg_o;
    prev_c = oreg_count_o;
  end

  task automatic send(input logic [NCH*DW-1:0] d);
    sample_valid_i = 1'b1;
    sample_data_i  = d;
    @(posedge clk); #1;
    sample_valid_i = 1'b0;
    sample_data_i  = '0;
  endtask

  task automatic win(input logic [NCH*DW-1:0] d, input bit pub);
    exp_t e;
    tb_seq++;
    if (pub) begin
      e.d = d;
      e.c = CW'(tb_seq);
      q.push_back(e);
    end
    send(d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", q.size(), 0);
    q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH*DW-1:0] held;
    rst = 1'b1; sample_valid_i = 1'b0; sample_data_i = '0;
    decim_i = '0; mode_i = MODE_LAST; freeze_i = 1'b0;
    idle(2);
    rst = 1'b0;
    chk("rst_oreg", oreg_o, 0);
    chk("rst_cnt", oreg_count_o, 0);
    chk("rst_frozen", frozen_o, 0);
    chk("rst_drop", drop_count_o, 0);
    @(negedge clk); #1;
    tb_in_rst = 1'b0;
    @(posedge clk); #1;

    // Single-sample window, last mode
    win(pk(5, -3, 7, 32'h7FFF_FFFF), 1'b1);
    drain();
    chk("t1_cnt", oreg_count_o, 1);

    // Sum mode over 4 samples with gaps, then modular wrap
    decim_i = 3; mode_i = MODE_SUM;
    win(pk(1, 0, 0, 0), 1'b0); tb_seq--; idle(1);
    win(pk(2, 0, 0, 0), 1'b0); tb_seq--; idle(2);
    win(pk(3, 0, 0, 0), 1'b0); tb_seq--;
    tb_seq++;
    q.push_back('{pk(10, 0, 0, 0), CW'(tb_seq)});
    send(pk(4, 0, 0, 0));
    drain();
    send(pk(32'h7FFF_FFFF, 0, 0, 0));
    send(pk(1, 0, 0, 0));
    send(pk(0, 0, 0, 0));
    tb_seq++;
    q.push_back('{pk(32'h8000_0000, 0, 0, 0), CW'(tb_seq)});
    send(pk(0, 0, 0, 0));
    drain();

    // Back-to-back single windows: one publish per cycle
    decim_i = 0; mode_i = MODE_LAST;
    for (int i = 0; i < 3; i++) win(pk(100 + i, 200 + i, 300 + i, 400 + i), 1'b1);
    drain();

    // Three windows while frozen: two drops, the last one published on release
    freeze_i = 1'b1; idle(1);
    chk("frozen_hi", frozen_o, 1);
    win(pk(11, 12, 13, 14), 1'b0);
    win(pk(21, 22, 23, 24), 1'b0);
    win(pk(31, 32, 33, 34), 1'b1);
    chk("drop2", drop_count_o, 2);
    freeze_i = 1'b0;
    drain();
    chk("frozen_lo", frozen_o, 0);
    tb_hold = tb_seq;

    // Freeze rising on a completion edge: window held in the shadow
    freeze_i = 1'b1;
    win(pk(41, 42, 43, 44), 1'b0);
    idle(2);
    chk("hold_cnt", oreg_count_o, tb_hold);
    q.push_back('{pk(41, 42, 43, 44), CW'(tb_seq)});
    freeze_i = 1'b0;
    drain();
    chk("drop_keep1", drop_count_o, 2);

    // Freeze falling on a completion edge: new window wins, shadow discarded
    freeze_i = 1'b1; idle(1);
    win(pk(51, 52, 53, 54), 1'b0);
    freeze_i = 1'b0;
    win(pk(61, 62, 63, 64), 1'b1);
    drain();
    idle(3);
    chk("drop_keep2", drop_count_o, 2);

    // Decimation change mid-window applies to the following window
    decim_i = 1;
    win(pk(70, 0, 0, 0), 1'b0); tb_seq--;
    decim_i = 4;
    win(pk(71, 1, 2, 3), 1'b1);
    drain();
    for (int i = 0; i < 4; i++) send(pk(80 + i, 0, 0, 0));
    win(pk(90, 9, 8, 7), 1'b1);
    drain();

    // Build drop=3, then reset mid-window while frozen
    decim_i = 0;
    freeze_i = 1'b1; idle(1);
    win(pk(1, 1, 1, 1), 1'b0);
    held = pk(2, 2, 2, 2);
    win(held, 1'b0);
    chk("drop3", drop_count_o, 3);
    decim_i = 1;
    send(pk(9, 9, 9, 9));
    tb_in_rst = 1'b1;
    rst = 1'b1;
    idle(1);
    rst = 1'b0; freeze_i = 1'b0;
    chk("rst2_oreg", oreg_o, 0);
    chk("rst2_cnt", oreg_count_o, 0);
    chk("rst2_frozen", frozen_o, 0);
    chk("rst2_drop", drop_count_o, 0);
    @(negedge clk); #1;
    tb_in_rst = 1'b0;
    @(posedge clk); #1;
    tb_seq = 0;
    win(pk(3, 4, 5, 6), 1'b0); tb_seq--;
    win(pk(7, 8, 9, 10), 1'b1);
    drain();
    chk("post_rst_cnt", oreg_count_o, 1);
    idle(2);

    $display("test done: total=%0d bad=%0d", tb_total, tb_bad);
    $finish;
  end
endmodule
